maxpool_seq: RTL and testbench

Control-side sequencer for the `maxpool` datapath: it accepts a valid/ready activation stream from the MVU output stage and drives `max_en`, `max_clr` and `max_pool` so that the datapath register ends each window holding the max of exactly `pool_len` elements. It announces each completed result to the downstream consumer with a valid/ready handshake and stalls the input while a result is unconsumed. Activation data routes straight to the datapath `I` port and never passes through this block.

---
 rtl/maxpool_pkg.sv | 6 +
 rtl/maxpool_seq.sv | 55 +++++
 tb/tb_maxpool_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared state encoding and default widths for the maxpool sequencer.
package maxpool_pkg;
  localparam int CNTW_D = 8;
  localparam int IDXW_D = 16;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
endpackage

// File: rtl/maxpool_seq.sv
// maxpool_seq: window sequencer driving the maxpool datapath strobes and the result handshake.
module maxpool_seq
  import maxpool_pkg::*;
#(
  parameter int CNTW = CNTW_D,
  parameter int IDXW = IDXW_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CNTW-1:0] pool_len,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            max_en,
  output logic            max_pool,
  output logic            max_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx
);
  state_t state;
  logic [CNTW-1:0] cnt, len, first_len, cnt_nxt;
  logic acc;
  assign in_ready  = rst_n & ~flush & ((state != HOLD) | out_ready);
  assign acc       = in_valid & in_ready;
  assign max_en    = acc;
  assign max_pool  = rst_n & (state == ACC);
  assign max_clr   = ~rst_n | flush;
  assign out_valid = rst_n & (state == HOLD);
  assign first_len = (pool_len == '0) ? CNTW'(1) : pool_len;
  assign cnt_nxt   = cnt + CNTW'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len     <= CNTW'(1);
      out_idx <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (acc && state != ACC) begin
      // a HOLD with acc means the result is consumed and a new window starts at once
      len   <= first_len;
      cnt   <= CNTW'(1);
      state <= (first_len == CNTW'(1)) ? HOLD : ACC;
      if (state == HOLD) out_idx <= out_idx + IDXW'(1);
    end else if (acc) begin
      cnt <= cnt_nxt;
      if (cnt_nxt == len) state <= HOLD;
    end else if (state == HOLD && out_ready) begin
      state   <= IDLE;
      out_idx <= out_idx + IDXW'(1);
    end
  end
endmodule

// File: tb/tb_maxpool_seq.sv
// tb_maxpool_seq: scoreboard bench with a behavioural maxpool datapath model.
module tb_maxpool_seq;
  typedef struct {
    logic signed [7:0] o;
    logic [15:0]       idx;
  } res_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [7:0] pool_len = 8'd1;
  logic in_ready, max_en, max_pool, max_clr, out_valid;
  logic [15:0] out_idx;
  logic signed [7:0] din = 0, o = 0;
  res_t exp_q[$], got_q[$];
  int pass = 0, total = 0;
  logic [15:0] exp_idx = 0;
  always #5 clk = ~clk;
  maxpool_seq dut (
    .clk(clk), .rst_n(rst_n), .pool_len(pool_len), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .max_en(max_en),
    .max_pool(max_pool), .max_clr(max_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx)
  );
  always @(posedge clk)
    if (max_clr) o <= 0;
    else if (max_en) o <= (max_pool && o > din) ? o : din;
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) got_q.push_back('{o, out_idx});
  task automatic push_exp(input logic signed [7:0] v);
    exp_q.push_back('{v, exp_idx});
    exp_idx = exp_idx + 16'd1;
  endtask
  // drives one element and returns the max_pool seen in its acceptance cycle
  task automatic send(input logic signed [7:0] v, output logic pool);
    int n = 0;
    in_valid = 1; din = v; pool = 1'bx;
    while (n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        pool = max_pool;
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    total++;
    $display("FAIL send_timeout got in_ready=0 want accept of %0d", v);
    in_valid = 0;
  endtask
  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin total++; $display("FAIL out_valid_timeout got 0 want 1"); end
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (max_clr !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || max_en !== 1'b0 || max_pool !== 1'b0)
        $display("FAIL reset_outputs got clr=%b rdy=%b ov=%b en=%b pool=%b want 1 0 0 0 0", max_clr, in_ready, out_valid, max_en, max_pool);
      else pass++;
    end
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    total++; if (max_clr !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 16'd0)
      $display("FAIL post_reset got clr=%b rdy=%b ov=%b idx=%0d want 0 1 0 0", max_clr, in_ready, out_valid, out_idx);
    else pass++;
    @(posedge clk); #1;
  endtask
  task automatic test_window4();
    logic signed [7:0] v[4] = '{3, -7, 9, 1};
    logic exp_p[4] = '{0, 1, 1, 1};
    logic p;
    pool_len = 4; out_ready = 1;
    push_exp(9);
    for (int i = 0; i < 4; i++) begin
      send(v[i], p);
      total++; if (p !== exp_p[i]) $display("FAIL w4_pool[%0d] got %b want %b", i, p, exp_p[i]); else pass++;
    end
    wait_out();
    total++; if (o !== 8'sd9 || out_idx !== 16'd0) $display("FAIL w4_result got O=%0d idx=%0d want 9 0", o, out_idx); else pass++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_idx !== 16'd1) $display("FAIL w4_after got ov=%b idx=%0d want 0 1", out_valid, out_idx); else pass++;
    @(posedge clk); #1;
  endtask
  task automatic test_backpressure();
    logic p;
    pool_len = 2; out_ready = 0;
    push_exp(5);
    send(5, p);
    send(2, p);
    push_exp(8);
    in_valid = 1; din = 8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || o !== 8'sd5)
        $display("FAIL bp_stall[%0d] got rdy=%b ov=%b O=%0d want 0 1 5", i, in_ready, out_valid, o);
      else pass++;
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || max_pool !== 1'b0 || max_en !== 1'b1)
      $display("FAIL bp_release got rdy=%b pool=%b en=%b want 1 0 1", in_ready, max_pool, max_en);
    else pass++;
    @(posedge clk); #1;
    send(3, p);
    total++; if (p !== 1'b1) $display("FAIL bp_second_pool got %b want 1", p); else pass++;
    wait_out();
    total++; if (o !== 8'sd8) $display("FAIL bp_result got O=%0d want 8", o); else pass++;
    @(posedge clk); #1;
  endtask
  task automatic test_len_one();
    logic signed [7:0] v[3] = '{-4, 5, 0};
    logic [7:0] lens[2] = '{0, 1};
    logic p;
    out_ready = 1;
    for (int l = 0; l < 2; l++) begin
      pool_len = lens[l];
      for (int i = 0; i < 3; i++) begin
        push_exp(v[i]);
        send(v[i], p);
        total++; if (p !== 1'b0) $display("FAIL len%0d_pool[%0d] got %b want 0", lens[l], i, p); else pass++;
      end
      wait_out();
      @(posedge clk); #1;
    end
  endtask
  task automatic test_flush();
    logic signed [7:0] v[3] = '{1, 9, 1};
    logic p;
    pool_len = 3; out_ready = 1;
    send(7, p);
    send(8, p);
    in_valid = 1; din = 50; flush = 1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || max_clr !== 1'b1 || max_en !== 1'b0)
      $display("FAIL flush_cycle got rdy=%b clr=%b en=%b want 0 1 0", in_ready, max_clr, max_en);
    else pass++;
    @(posedge clk); #1; flush = 0; in_valid = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_idx !== exp_idx || o !== 8'sd0)
      $display("FAIL flush_after got ov=%b idx=%0d O=%0d want 0 %0d 0", out_valid, out_idx, o, exp_idx);
    else pass++;
    @(posedge clk); #1;
    push_exp(9);
    for (int i = 0; i < 3; i++) begin
      send(v[i], p);
      total++; if (p !== (i != 0)) $display("FAIL flush_pool[%0d] got %b want %b", i, p, i != 0); else pass++;
    end
    wait_out();
    total++; if (o !== 8'sd9) $display("FAIL flush_result got O=%0d want 9", o); else pass++;
    @(posedge clk); #1;
  endtask
  task automatic test_len_change();
    logic p;
    pool_len = 3; out_ready = 1;
    push_exp(6);
    send(2, p);
    pool_len = 2;
    send(6, p);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL lc_early got ov=%b want 0", out_valid); else pass++;
    @(posedge clk); #1;
    send(4, p);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || o !== 8'sd6) $display("FAIL lc_first got ov=%b O=%0d want 1 6", out_valid, o); else pass++;
    @(posedge clk); #1;
    push_exp(5);
    send(5, p);
    send(1, p);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || o !== 8'sd5) $display("FAIL lc_second got ov=%b O=%0d want 1 5", out_valid, o); else pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask
  task automatic test_scoreboard();
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL sb_count got %0d want %0d", got_q.size(), exp_q.size()); else pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      res_t e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g.o !== e.o || g.idx !== e.idx)
        $display("FAIL sb_result got O=%0d idx=%0d want O=%0d idx=%0d", g.o, g.idx, e.o, e.idx);
      else pass++;
    end
  endtask
  initial begin
    test_reset();
    test_window4();
    test_backpressure();
    test_len_one();
    test_flush();
    test_len_change();
    test_scoreboard();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
